// File: rtl/tx_lvds_pkg.sv
// Shared definitions for the 7:1 LVDS transmit serializer and its receive-side alignment logic.
// Holds the FSM state type, the default lane patterns and the lane bit mapping.
package tx_lvds_pkg;

    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_RATIO = 7;

    localparam logic [6:0] DEF_CLK_PATTERN   = 7'b1100011;
    localparam logic [6:0] DEF_TRAIN_PATTERN = 7'b1110000;
    localparam logic [6:0] DEF_IDLE_WORD     = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_t;

    // Lane l occupies bits [l*ratio +: ratio] of the parallel word; bit ratio-1 leaves first.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned ratio);
        return lane * ratio;
    endfunction

endpackage

// File: rtl/tx_lvds_lane_shift.sv
// One RATIO-bit parallel-load, MSB-first shift register; the MSB drives the serial pin directly.
module tx_lvds_lane_shift #(
    parameter int unsigned      RATIO      = 7,
    parameter logic [RATIO-1:0] RESET_WORD = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [RATIO-1:0] load_word,
    output logic             msb
);

    logic [RATIO-1:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= RESET_WORD;
        end else if (load) begin
            shreg <= load_word;
        end else begin
            shreg <= {shreg[RATIO-2:0], 1'b0};
        end
    end

    assign msb = shreg[RATIO-1];

endmodule

// File: rtl/tx_lvds_serializer.sv
// Soft 7:1 LVDS-style transmit serializer: data lanes plus forwarded clock lane, training mode,
// valid/ready holding register and saturating underflow accounting, all in the serial clock domain.
module tx_lvds_serializer
    import tx_lvds_pkg::*;
#(
    parameter int unsigned      LANES         = DEF_LANES,
    parameter int unsigned      RATIO         = DEF_RATIO,
    parameter logic [RATIO-1:0] CLK_PATTERN   = DEF_CLK_PATTERN,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter logic [RATIO-1:0] IDLE_WORD     = DEF_IDLE_WORD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   train_en,
    input  logic [LANES*RATIO-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [LANES-1:0]       ser_data,
    output logic                   ser_clk,
    output logic                   word_start,
    output logic                   underflow,
    output logic [15:0]            underflow_cnt
);

    localparam int unsigned      CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]       cnt;
    logic                   load;
    tx_state_t              state, state_nxt;
    logic                   hold_valid;
    logic [LANES*RATIO-1:0] hold_data;
    logic [LANES*RATIO-1:0] load_words;
    logic                   consume;
    logic                   uf_event;
    logic [15:0]            ucnt_q, ucnt_nxt;

    assign load    = (cnt == CNT_LAST);
    assign s_ready = !hold_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word selection always reflects the current state; transitions and side effects only on load.
    always_comb begin
        state_nxt  = state;
        load_words = {LANES{IDLE_WORD}};
        consume    = 1'b0;
        uf_event   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    if (train_en)    state_nxt = ST_TRAIN;
                    else if (enable) state_nxt = ST_RUN;
                end
            end
            ST_TRAIN: begin
                load_words = {LANES{TRAIN_PATTERN}};
                if (load && !train_en) begin
                    state_nxt = enable ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hold_valid) begin
                    load_words = hold_data;
                    consume    = load;
                end else begin
                    uf_event   = load;
                end
                if (load) begin
                    if (train_en)     state_nxt = ST_TRAIN;
                    else if (!enable) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (s_valid && s_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= s_data;
        end else if (consume) begin
            hold_valid <= 1'b0;
        end
    end

    assign ucnt_nxt = (uf_event && (ucnt_q != '1)) ? ucnt_q + 16'd1 : ucnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_start <= 1'b1;
            underflow  <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            word_start <= load;
            underflow  <= uf_event;
            ucnt_q     <= ucnt_nxt;
        end
    end

    assign underflow_cnt = ucnt_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        tx_lvds_lane_shift #(
            .RATIO      (RATIO),
            .RESET_WORD ('0)
        ) u_shift (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .load_word (load_words[lane_lsb(l, RATIO) +: RATIO]),
            .msb       (ser_data[l])
        );
    end

    tx_lvds_lane_shift #(
        .RATIO      (RATIO),
        .RESET_WORD (CLK_PATTERN)
    ) u_clk_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (CLK_PATTERN),
        .msb       (ser_clk)
    );

endmodule
